// File: rtl/noc_pkg.sv
// Shared flit layout for the mesh node interface: {dst, src, payload}.
// Default widths, field offsets and field pack/unpack helpers.
package noc_pkg;

    localparam int DEF_FLIT_W = 20;
    localparam int DEF_POS_W  = 4;

    localparam int PL_W    = DEF_FLIT_W - 2*DEF_POS_W;
    localparam int SRC_LSB = PL_W;
    localparam int DST_LSB = PL_W + DEF_POS_W;

    typedef logic [DEF_FLIT_W-1:0] flit_t;
    typedef logic [DEF_POS_W-1:0]  pos_t;
    typedef logic [PL_W-1:0]       payload_t;

    function automatic pos_t flit_dst(input flit_t f);
        return f[DST_LSB +: DEF_POS_W];
    endfunction

    function automatic pos_t flit_src(input flit_t f);
        return f[SRC_LSB +: DEF_POS_W];
    endfunction

    function automatic payload_t flit_payload(input flit_t f);
        return f[PL_W-1:0];
    endfunction

    function automatic flit_t make_flit(input pos_t dst, input pos_t src, input payload_t pl);
        return {dst, src, pl};
    endfunction

endpackage

// File: rtl/node_net_if_if.sv
// PE-side and router-side signal bundle of the node network interface.
// slave is the interface block itself; master is the PE plus router.
interface node_net_if_if
    import noc_pkg::*;
#(
    parameter int FLIT_W = DEF_FLIT_W,
    parameter int POS_W  = DEF_POS_W
);

    localparam int PAY_W = FLIT_W - 2*POS_W;

    logic [PAY_W-1:0]  tx_data;
    logic [POS_W-1:0]  tx_dst;
    logic              tx_valid;
    logic              tx_ready;

    logic [FLIT_W-1:0] inj_flit;
    logic              inj_valid;
    logic              inj_credit;

    logic [FLIT_W-1:0] ej_flit;
    logic              ej_valid;
    logic              ej_credit;

    logic [PAY_W-1:0]  rx_data;
    logic [POS_W-1:0]  rx_src;
    logic              rx_valid;
    logic              rx_ready;

    modport slave (
        input  tx_data, tx_dst, tx_valid, inj_credit, ej_flit, ej_valid, rx_ready,
        output tx_ready, inj_flit, inj_valid, ej_credit, rx_data, rx_src, rx_valid
    );

    modport master (
        output tx_data, tx_dst, tx_valid, inj_credit, ej_flit, ej_valid, rx_ready,
        input  tx_ready, inj_flit, inj_valid, ej_credit, rx_data, rx_src, rx_valid
    );

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; DEPTH must be a power of two.
// A write while full is accepted only when a read frees a slot on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/node_net_if.sv
// Network interface between a PE and the local port of a mesh router:
// buffered injection under router credits, buffered ejection returning credits.
module node_net_if
    import noc_pkg::*;
#(
    parameter int  FLIT_W    = DEF_FLIT_W,
    parameter int  POS_W     = DEF_POS_W,
    parameter int  INJ_DEPTH = 4,
    parameter int  EJ_DEPTH  = 4,
    parameter int  CREDITS   = 4,
    localparam int CNT_W     = $clog2(CREDITS+1)
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [POS_W-1:0] position,
    node_net_if_if.slave     bus,
    output logic [CNT_W-1:0] credit_cnt,
    output logic             err_misroute,
    output logic             err_overflow,
    output logic             err_credit
);

    localparam int PAY_W  = FLIT_W - 2*POS_W;
    localparam int RX_W   = POS_W + PAY_W;
    localparam int PEND_W = $clog2(EJ_DEPTH+1) + 1;
    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(CREDITS);

    logic              inj_full;
    logic              inj_empty;
    logic              inj_push;
    logic              inj_pop;
    logic [FLIT_W-1:0] inj_head;
    logic [FLIT_W-1:0] inj_flit_q;
    logic              inj_valid_q;

    assign bus.tx_ready  = !inj_full;
    assign inj_push      = bus.tx_valid && !inj_full;
    assign inj_pop       = !inj_empty && (credit_cnt != '0);
    assign bus.inj_flit  = inj_flit_q;
    assign bus.inj_valid = inj_valid_q;

    sync_fifo #(.WIDTH(FLIT_W), .DEPTH(INJ_DEPTH)) u_inj_fifo (
        .clk     (clk),
        .rst_n   (RST),
        .wr_en   (inj_push),
        .wr_data ({bus.tx_dst, position, bus.tx_data}),
        .rd_en   (inj_pop),
        .rd_data (inj_head),
        .full    (inj_full),
        .empty   (inj_empty)
    );

    // A returned credit is only usable from the following edge; no bypass into inj_pop.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            inj_valid_q <= 1'b0;
            inj_flit_q  <= '0;
            credit_cnt  <= CREDIT_MAX;
            err_credit  <= 1'b0;
        end else begin
            inj_valid_q <= inj_pop;
            if (inj_pop) inj_flit_q <= inj_head;
            case ({inj_pop, bus.inj_credit})
                2'b10: credit_cnt <= credit_cnt - 1'b1;
                2'b01: begin
                    if (credit_cnt == CREDIT_MAX) err_credit <= 1'b1;
                    else                          credit_cnt <= credit_cnt + 1'b1;
                end
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

    logic [POS_W-1:0]  ej_dst;
    logic              ej_full;
    logic              ej_empty;
    logic              ej_hit;
    logic              ej_write;
    logic              ej_discard;
    logic              rx_pop;
    logic [RX_W-1:0]   rx_head;
    logic [PEND_W-1:0] pend;
    logic [PEND_W-1:0] pend_add;
    logic              pend_issue;
    logic              ej_credit_q;

    assign ej_dst     = bus.ej_flit[RX_W +: POS_W];
    assign ej_hit     = bus.ej_valid && (ej_dst == position);
    assign ej_write   = ej_hit && !ej_full;
    // Misrouted flits still held a router credit, so hand it back unless the flit overflowed.
    assign ej_discard = bus.ej_valid && !ej_hit && !ej_full;
    assign rx_pop     = !ej_empty && bus.rx_ready;
    assign pend_issue = (pend != '0);
    assign pend_add   = PEND_W'(rx_pop) + PEND_W'(ej_discard);

    assign bus.rx_valid  = !ej_empty;
    assign bus.rx_src    = rx_head[RX_W-1 -: POS_W];
    assign bus.rx_data   = rx_head[PAY_W-1:0];
    assign bus.ej_credit = ej_credit_q;

    sync_fifo #(.WIDTH(RX_W), .DEPTH(EJ_DEPTH)) u_ej_fifo (
        .clk     (clk),
        .rst_n   (RST),
        .wr_en   (ej_write),
        .wr_data (bus.ej_flit[RX_W-1:0]),
        .rd_en   (rx_pop),
        .rd_data (rx_head),
        .full    (ej_full),
        .empty   (ej_empty)
    );

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            pend         <= '0;
            ej_credit_q  <= 1'b0;
            err_misroute <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            pend        <= pend + pend_add - PEND_W'(pend_issue);
            ej_credit_q <= pend_issue;
            if (bus.ej_valid && !ej_hit) err_misroute <= 1'b1;
            if (bus.ej_valid && ej_full) err_overflow <= 1'b1;
        end
    end

endmodule
